dcp_dump: RTL



---
 rtl/dcp_pkg.sv | 35 +++
 rtl/dcp_tx_seq.sv | 43 ++++
 rtl/dcp_dump.sv | 196 +++++++++++++++++++
 3 files changed

// File: rtl/dcp_pkg.sv
// Shared definitions for the DCP command blocks: dump FSM states, ASCII
// framing characters and transmit payload types.
package dcp_pkg;

  typedef enum logic [3:0] {
    StIdle,
    StScan,
    StPCmd,
    StPDash,
    StPAddr,
    StPColon,
    StRd,
    StPData,
    StPSep,
    StPCr,
    StPLf,
    StDone,
    StRearm
  } dcp_state_e;

  localparam logic [7:0] CH_DASH  = 8'h2D;
  localparam logic [7:0] CH_COLON = 8'h3A;
  localparam logic [7:0] CH_SPACE = 8'h20;
  localparam logic [7:0] CH_CR    = 8'h0D;
  localparam logic [7:0] CH_LF    = 8'h0A;

  localparam logic TYPE_CHAR = 1'b0;
  localparam logic TYPE_WORD = 1'b1;

  // Place an ASCII character in the low byte of a transmit payload.
  function automatic logic [31:0] char_word(input logic [7:0] i_ch);
    return {24'h0, i_ch};
  endfunction

endpackage

// File: rtl/dcp_tx_seq.sv
// Generic req/ack transmit driver: a load captures payload and type and raises
// req, which is held until ack; o_done marks the accepting cycle.
module dcp_tx_seq
  import dcp_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        i_load,
  input  logic [31:0] i_data,
  input  logic        i_type,
  input  logic        i_ack,
  output logic        o_req,
  output logic        o_type,
  output logic [31:0] o_data,
  output logic        o_done
);

  logic        r_req;
  logic        r_type;
  logic [31:0] r_data;

  // Capture payload on load, hold req until ack, drop it on the following edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_req  <= 1'b0;
      r_type <= TYPE_CHAR;
      r_data <= 32'h0;
    end else if (i_load) begin
      r_req  <= 1'b1;
      r_type <= i_type;
      r_data <= i_data;
    end else if (r_req && i_ack) begin
      r_req <= 1'b0;
    end
  end

  // An ack seen while req is low is ignored.
  assign o_done = r_req & i_ack;
  assign o_req  = r_req;
  assign o_type = r_type;
  assign o_data = r_data;

endmodule

// File: rtl/dcp_dump.sv
// Memory-dump command processor. Prints NLINES lines of the form
// <CMD_CHAR>-<addr>:<w0>..<wN-1>\r\n, continuing from the last dumped address
// when no operand is typed.
// Build option: define DCP_DUMP_SEP_EN to insert a space between data words.
module dcp_dump
  import dcp_pkg::*;
#(
  parameter logic [7:0]  CMD_CHAR = 8'h44,
  parameter int unsigned ADDR_W   = 32,
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned NWORDS   = 8,
  parameter int unsigned NLINES   = 1,
  parameter int unsigned MEM_LAT  = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        sel_mode,
  output logic              finish,
  output logic              req_rx,
  output logic              type_rx,
  input  logic [31:0]       din_rx,
  input  logic              flag_rx,
  input  logic              ack_rx,
  output logic              req_tx,
  output logic              type_tx,
  output logic [31:0]       dout,
  input  logic              ack_tx,
  output logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] din_mem
);

  localparam logic [7:0] W_LAST = 8'(NWORDS - 1);
  localparam logic [7:0] L_LAST = 8'(NLINES - 1);
  localparam logic [2:0] LAT_C  = 3'(MEM_LAT);
  localparam logic [ADDR_W-1:0] ADDR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

  dcp_state_e        r_state;
  logic [ADDR_W-1:0] r_cur;
  logic [ADDR_W-1:0] r_last;
  logic [7:0]        r_wcnt;
  logic [7:0]        r_lcnt;
  logic [2:0]        r_lat;
  logic [31:0]       r_word;
  logic              r_sent;
  logic              r_load;
  logic [31:0]       r_tx_data;
  logic              r_tx_type;
  logic              r_req_rx;
  logic              r_finish;

  logic              w_done;
  logic [31:0]       w_payload;
  logic              w_ptype;

  dcp_tx_seq u_tx_seq (
    .clk    (clk),
    .rst    (rst),
    .i_load (r_load),
    .i_data (r_tx_data),
    .i_type (r_tx_type),
    .i_ack  (ack_tx),
    .o_req  (req_tx),
    .o_type (type_tx),
    .o_data (dout),
    .o_done (w_done)
  );

  // Payload and type for the character or word belonging to each print state.
  always_comb begin
    w_payload = 32'h0;
    w_ptype   = TYPE_CHAR;
    case (r_state)
      StPCmd:   w_payload = char_word(CMD_CHAR);
      StPDash:  w_payload = char_word(CH_DASH);
      StPAddr: begin
        w_payload = 32'(r_cur);
        w_ptype   = TYPE_WORD;
      end
      StPColon: w_payload = char_word(CH_COLON);
      StPData: begin
        w_payload = r_word;
        w_ptype   = TYPE_WORD;
      end
      StPSep:   w_payload = char_word(CH_SPACE);
      StPCr:    w_payload = char_word(CH_CR);
      StPLf:    w_payload = char_word(CH_LF);
      default:  ;
    endcase
  end

  // Command sequencer: operand fetch, line framing, memory reads and rearm.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= StIdle;
      r_cur     <= '0;
      r_last    <= '0;
      r_wcnt    <= 8'h0;
      r_lcnt    <= 8'h0;
      r_lat     <= 3'h0;
      r_word    <= 32'h0;
      r_sent    <= 1'b0;
      r_load    <= 1'b0;
      r_tx_data <= 32'h0;
      r_tx_type <= TYPE_CHAR;
      r_req_rx  <= 1'b0;
      r_finish  <= 1'b0;
    end else begin
      r_load   <= 1'b0;
      r_finish <= 1'b0;
      case (r_state)
        StIdle: begin
          if (sel_mode == CMD_CHAR) begin
            r_req_rx <= 1'b1;
            r_state  <= StScan;
          end
        end
        StScan: begin
          if (r_req_rx && ack_rx) begin
            r_req_rx <= 1'b0;
            r_cur    <= flag_rx ? r_last : din_rx[ADDR_W-1:0];
            r_wcnt   <= 8'h0;
            r_lcnt   <= 8'h0;
            r_sent   <= 1'b0;
            r_state  <= StPCmd;
          end
        end
        StRd: begin
          // addr follows r_cur, so the count starts at the address change.
          if (r_lat == LAT_C) begin
            r_word  <= 32'(din_mem);
            r_lat   <= 3'h0;
            r_state <= StPData;
          end else begin
            r_lat <= r_lat + 3'h1;
          end
        end
        StPCmd, StPDash, StPAddr, StPColon, StPData, StPSep, StPCr, StPLf: begin
          if (!r_sent) begin
            r_sent    <= 1'b1;
            r_load    <= 1'b1;
            r_tx_data <= w_payload;
            r_tx_type <= w_ptype;
          end else if (w_done) begin
            r_sent <= 1'b0;
            case (r_state)
              StPCmd:   r_state <= StPDash;
              StPDash:  r_state <= StPAddr;
              StPAddr:  r_state <= StPColon;
              StPColon: r_state <= StRd;
              StPData: begin
                r_cur <= r_cur + ADDR_ONE;
                if (r_wcnt < W_LAST) begin
                  r_wcnt <= r_wcnt + 8'h1;
`ifdef DCP_DUMP_SEP_EN
                  r_state <= StPSep;
`else
                  r_state <= StRd;
`endif
                end else begin
                  r_state <= StPCr;
                end
              end
              StPSep:   r_state <= StRd;
              StPCr:    r_state <= StPLf;
              StPLf: begin
                if (r_lcnt < L_LAST) begin
                  r_lcnt  <= r_lcnt + 8'h1;
                  r_wcnt  <= 8'h0;
                  r_state <= StPCmd;
                end else begin
                  r_state <= StDone;
                end
              end
              default:  r_state <= StIdle;
            endcase
          end
        end
        StDone: begin
          r_last   <= r_cur;
          r_finish <= 1'b1;
          r_state  <= StRearm;
        end
        StRearm: begin
          if (sel_mode != CMD_CHAR) r_state <= StIdle;
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  assign addr    = r_cur;
  assign finish  = r_finish;
  assign req_rx  = r_req_rx;
  assign type_rx = TYPE_WORD;

endmodule
